// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the branch-comparator arbiter.
package cmp_arb_pkg;

    localparam int CMP_XLEN = 32;
    localparam int PERF_W   = 16;

    typedef enum logic {S_IDLE, S_RESP} cmp_arb_state_e;

    typedef struct packed {
        logic [CMP_XLEN-1:0] rs1;
        logic [CMP_XLEN-1:0] rs2;
        logic                un;
    } cmp_req_t;

    // Index width for an N-way selector; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_arbiter_if.sv
// Requester/response bus between compare requesters and cmp_arbiter.
interface cmp_arbiter_if #(
    parameter int NREQ = 2,
    parameter int XLEN = cmp_arb_pkg::CMP_XLEN
);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_rs1;
    logic [NREQ*XLEN-1:0] req_rs2;
    logic [NREQ-1:0]      req_un;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic                 rsp_eq;
    logic                 rsp_lt;

    modport master (
        output req_valid, req_rs1, req_rs2, req_un, rsp_ready,
        input  req_ready, rsp_valid, rsp_eq, rsp_lt
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_un, rsp_ready,
        output req_ready, rsp_valid, rsp_eq, rsp_lt
    );

endinterface

// File: rtl/cmp_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NREQ.
module rr_arbiter
    import cmp_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    int          cand;
    logic [IW-1:0] cidx;

    // NOTE: every output gets a default before the search so no path leaves a latch.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cidx      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            cidx = IW'(cand);
            if (!grant_any && req[cidx]) begin
                grant_any      = 1'b1;
                grant_idx      = cidx;
                grant_oh[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one branch comparator among NREQ requesters, registered flags.
// Optional CMP_ARB_PERF_EN adds a saturating conflict counter on perf_conflict_cnt.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = CMP_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    cmp_arbiter_if.slave    bus,
    output logic [XLEN-1:0] cmp_rs1,
    output logic [XLEN-1:0] cmp_rs2,
    output logic            cmp_un,
    input  logic            cmp_eq,
    input  logic            cmp_lt
`ifdef CMP_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_conflict_cnt
`endif
);

    localparam int IW = idx_w(NREQ);

    cmp_arb_state_e  state_q, state_d;
    logic [IW-1:0]   owner_q, ptr_q, grant_idx;
    logic [NREQ-1:0] arb_req, grant_oh, rsp_valid_vec;
    logic            grant_any, owner_done, accept_window;
    logic            rsp_eq_q, rsp_lt_q;

    // A new compare may enter while the owner drains its result in the same cycle.
    assign owner_done    = (state_q == S_RESP) && bus.rsp_ready[owner_q];
    assign accept_window = (state_q == S_IDLE) || owner_done;
    assign arb_req       = accept_window ? bus.req_valid : '0;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (arb_req),
        .ptr       (ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign bus.req_ready = grant_oh;

    always_comb begin
        cmp_rs1 = '0;
        cmp_rs2 = '0;
        cmp_un  = 1'b0;
        if (grant_any) begin
            cmp_rs1 = bus.req_rs1[int'(grant_idx)*XLEN +: XLEN];
            cmp_rs2 = bus.req_rs2[int'(grant_idx)*XLEN +: XLEN];
            cmp_un  = bus.req_un[grant_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        if (grant_any) begin
            state_d = S_RESP;
        end else if (owner_done) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        rsp_valid_vec = '0;
        if (state_q == S_RESP) begin
            rsp_valid_vec[owner_q] = 1'b1;
        end
    end

    assign bus.rsp_valid = rsp_valid_vec;
    assign bus.rsp_eq    = rsp_eq_q;
    assign bus.rsp_lt    = rsp_lt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            ptr_q    <= IW'(NREQ - 1);
            rsp_eq_q <= 1'b0;
            rsp_lt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                owner_q  <= grant_idx;
                ptr_q    <= grant_idx;
                rsp_eq_q <= cmp_eq;
                // Equal operands always win over less-than, even from a glitchy comparator.
                rsp_lt_q <= cmp_lt & ~cmp_eq;
            end
        end
    end

`ifdef CMP_ARB_PERF_EN
    logic conflict;

    assign conflict = accept_window && ($countones(bus.req_valid) > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflict_cnt <= '0;
        end else if (conflict && (perf_conflict_cnt != {PERF_W{1'b1}})) begin
            perf_conflict_cnt <= perf_conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus random traffic vs. a transaction model.
module tb_cmp_arbiter;
    import cmp_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] cmp_rs1, cmp_rs2;
    logic            cmp_un, cmp_eq, cmp_lt;
`ifdef CMP_ARB_PERF_EN
    logic [15:0]     perf_conflict_cnt;
`endif

    cmp_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

    cmp_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cmp_rs1 (cmp_rs1),
        .cmp_rs2 (cmp_rs2),
        .cmp_un  (cmp_un),
        .cmp_eq  (cmp_eq),
        .cmp_lt  (cmp_lt)
`ifdef CMP_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the datapath comparator.
    assign cmp_eq = (cmp_rs1 == cmp_rs2);
    assign cmp_lt = cmp_un ? (cmp_rs1 < cmp_rs2) : ($signed(cmp_rs1) < $signed(cmp_rs2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Transaction-level model: one pending result, who owns it, and who was served last.
    cmp_req_t tb_req [NREQ];
    bit       m_pend;
    int       m_owner;
    int       m_last;
    bit       m_eq, m_lt;
    int       m_perf;
    int       last_grant;

    task automatic model_reset();
        m_pend  = 0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_eq    = 0;
        m_lt    = 0;
        m_perf  = 0;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", bus.rsp_valid, '0);
        check("rst_req_ready", bus.req_ready, '0);
        check("rst_rsp_eq",    bus.rsp_eq,    1'b0);
        check("rst_rsp_lt",    bus.rsp_lt,    1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at the falling edge, check, then advance the model to the next rising edge.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr);
        bit              win;
        int              g;
        logic [NREQ-1:0] exp_rdy, exp_vld;
        logic [XLEN-1:0] a, b;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_rs1[i*XLEN +: XLEN] = tb_req[i].rs1;
            bus.req_rs2[i*XLEN +: XLEN] = tb_req[i].rs2;
            bus.req_un[i]               = tb_req[i].un;
        end
        bus.req_valid = v;
        bus.rsp_ready = rr;
        #1;
        win = !m_pend || (rr[m_owner] == 1'b1);
        g   = -1;
        if (win) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && v[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
            end
        end
        exp_rdy = '0;
        exp_vld = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        if (m_pend) exp_vld[m_owner] = 1'b1;
        a = (g >= 0) ? tb_req[g].rs1 : '0;
        b = (g >= 0) ? tb_req[g].rs2 : '0;
        check("req_ready", bus.req_ready, exp_rdy);
        check("rsp_valid", bus.rsp_valid, exp_vld);
        check("rsp_eq",    bus.rsp_eq,    m_eq);
        check("rsp_lt",    bus.rsp_lt,    m_lt);
        check("cmp_rs1",   cmp_rs1,       a);
        check("cmp_rs2",   cmp_rs2,       b);
        check("cmp_un",    cmp_un,        (g >= 0) ? tb_req[g].un : 1'b0);
        last_grant = g;
        if (win && $countones(v) >= 2 && m_perf < 16'hFFFF) m_perf++;
        if (g >= 0) begin
            m_eq    = (a == b);
            m_lt    = tb_req[g].un ? (a < b) : ($signed(a) < $signed(b));
            m_pend  = 1;
            m_owner = g;
            m_last  = g;
        end else if (m_pend && rr[m_owner]) begin
            m_pend = 0;
        end
    endtask

    task automatic set_req(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic u);
        tb_req[i].rs1 = a;
        tb_req[i].rs2 = b;
        tb_req[i].un  = u;
    endtask

    initial begin
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.req_un  = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, '0, '0, 1'b0);
        do_reset();

        // Signed compare: -100 < 100.
        set_req(0, 32'hFFFF_FF9C, 32'd100, 1'b0);
        cycle(2'b01, 2'b00);
        cycle(2'b00, 2'b00);
        check("signed_valid", bus.rsp_valid, 2'b01);
        check("signed_eq",    bus.rsp_eq,    1'b0);
        check("signed_lt",    bus.rsp_lt,    1'b1);

        // Backpressure: owner holds its result; a waiting request is not accepted.
        set_req(0, 32'hFFFF_FF9C, 32'd100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(2'b01, 2'b00);
            check("bp_no_ready", bus.req_ready, 2'b00);
            check("bp_lt_hold",  bus.rsp_lt,    1'b1);
        end
        cycle(2'b01, 2'b01);
        check("bp_release_accept", bus.req_ready, 2'b01);

        // Unsigned: 0xFFFFFF9C is larger than 100.
        cycle(2'b00, 2'b01);
        check("unsigned_eq", bus.rsp_eq, 1'b0);
        check("unsigned_lt", bus.rsp_lt, 1'b0);

        set_req(0, 32'd7, 32'd7, 1'b1);
        cycle(2'b01, 2'b00);
        cycle(2'b00, 2'b01);
        check("equal_eq", bus.rsp_eq, 1'b1);
        check("equal_lt", bus.rsp_lt, 1'b0);

        // Reset while a response is pending.
        cycle(2'b01, 2'b00);
        @(posedge clk);
        #2;
        do_reset();
        cycle(2'b00, 2'b00);
        check("post_rst_no_valid", bus.rsp_valid, 2'b00);

        // Round-robin: both requesting and both draining, one grant per cycle starting at 0.
        set_req(0, 32'd5, 32'd9, 1'b0);
        set_req(1, 32'h8000_0000, 32'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(2'b11, 2'b11);
            check("rr_grant", last_grant, i % 2);
        end
`ifdef CMP_ARB_PERF_EN
        check("perf_10", perf_conflict_cnt, 16'd10);
`endif

        // Random traffic with frequent equal operands and sign-boundary values.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                logic [XLEN-1:0] a, b;
                a = $urandom();
                b = ($urandom_range(3) == 0) ? a : XLEN'($urandom());
                if ($urandom_range(7) == 0) a = 32'h8000_0000;
                set_req(i, a, b, 1'($urandom_range(1)));
            end
            cycle(NREQ'($urandom()), NREQ'($urandom()));
        end
`ifdef CMP_ARB_PERF_EN
        check("perf_final", perf_conflict_cnt, 16'(m_perf));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
